game_round_ctrl: RTL and testbench
==================================

# game_round_ctrl

Sequences a single game round once the top-level game-mode FSM has selected GAME1 or GAME2. It runs a start countdown, a timed play phase with pause/resume, and a game-over hold. Its `run` output gates the sprite/physics logic, and it reports remaining time and score to the HUD. Key commands come from the same two USB keycode slots that the game-mode FSM uses; frame timing comes from the VGA vertical-sync tick.

## Interface
Parameters:
- FRAMES_PER_SEC, 60, frame_tick pulses per second (2..255)
- COUNTDOWN_SEC, 3, pre-round countdown length in seconds (1..15)
- ROUND_SEC, 60, play-phase length in seconds (1..255)
- SCORE_LIMIT, 10, score that ends the round (1..255)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  reset: asynchronous, active-low
- game_active  in  1  high while the game-mode FSM is in GAME1 or GAME2
- frame_tick  in  1  one-cycle pulse per video frame
- keycode, keycode2  in  8 each  USB keycode slots
- score_event  in  1  one-cycle pulse per point scored
- run  out  1  game logic enable
- paused  out  1  high in PAUSE
- game_over  out  1  high in OVER
- round_start  out  1  one-cycle pulse on entry to PLAY
- countdown  out  4  seconds left in the countdown
- time_left  out  8  seconds left in play
- score  out  8  current score

## Operation
- Key press: `k_pressed` is true when `keycode` or `keycode2` equals the key code.
- Key edge: `k_pressed` AND NOT `k_prev`, where `k_prev` is a register updated every cycle and reset to 0.
- Command keys: START = 8'h2C (space), PAUSE = 8'h13 ('P').
- Internal frame counter `fcnt`, range 0..FRAMES_PER_SEC-1.
- A second boundary (`sec`) occurs when frame_tick=1 and fcnt=FRAMES_PER_SEC-1; fcnt then wraps to 0. On any other frame_tick, fcnt increments.
- fcnt advances only in COUNTDOWN and PLAY, holds in PAUSE, and is cleared in IDLE and OVER.

State machine. States are IDLE, COUNTDOWN, PLAY, PAUSE, OVER. Highest priority in every state: game_active=0 moves to IDLE at the next edge.
- IDLE:
  - run=0; score=0; time_left=ROUND_SEC; countdown=COUNTDOWN_SEC.
  - START edge with game_active=1 moves to COUNTDOWN.
- COUNTDOWN:
  - On `sec`, countdown decrements.
  - When `sec` occurs with countdown=1: countdown becomes 0, move to PLAY, and assert round_start for exactly one cycle in the first PLAY cycle.
  - Keys are ignored.
- PLAY:
  - run=1.
  - On `sec`, time_left decrements.
  - On score_event, score increments, saturating at SCORE_LIMIT.
  - Move to OVER when `sec` occurs with time_left=1 (time_left becomes 0), or when score_event occurs with score=SCORE_LIMIT-1 (score becomes SCORE_LIMIT). If both happen in the same cycle, both updates apply.
  - Otherwise, a PAUSE edge moves to PAUSE. OVER has priority over PAUSE.
- PAUSE:
  - run=0; paused=1.
  - frame_tick and score_event are ignored; time_left, score and fcnt hold.
  - PAUSE edge moves back to PLAY; round_start is not pulsed.
- OVER:
  - run=0; game_over=1; score and time_left hold.
  - START edge moves to COUNTDOWN, with score reset to 0, time_left to ROUND_SEC, countdown to COUNTDOWN_SEC, and fcnt to 0.

## Timing
- Reset values:
  - state = IDLE; run, paused, game_over, round_start = 0.
  - countdown = COUNTDOWN_SEC; time_left = ROUND_SEC; score = 0; fcnt = 0; k_prev = 0.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Latency:
  - A key edge sampled at edge N changes the state and outputs after edge N.
  - A key held continuously produces only one edge.
- Countdown length: exactly COUNTDOWN_SEC×FRAMES_PER_SEC frame_ticks from COUNTDOWN entry to PLAY.
- Play length with no pause: exactly ROUND_SEC×FRAMES_PER_SEC frame_ticks.
- Pausing mid-second resumes from the held fcnt, so no partial second is lost.
- A START or PAUSE key pressed in both slots at once counts as a single edge.
- Asserting Reset_n low mid-round forces the reset values asynchronously; operation resumes in IDLE at the first edge after release.
- Dropping game_active mid-round (e.g. Esc handled by the game-mode FSM) reaches IDLE in one cycle, with score and time reloaded.

## Test plan
Bench parameters: FRAMES_PER_SEC=4, COUNTDOWN_SEC=2, ROUND_SEC=3, SCORE_LIMIT=3.
- **Start and countdown.** game_active=1, keycode=8'h2C for 1 cycle, then 8 frame_ticks. Required: countdown goes 2→1→0; PLAY is entered on the 8th tick; round_start pulses once; run=1.
- **Timeout.** In PLAY, 12 frame_ticks. Required: time_left goes 3→2→1→0; OVER with game_over=1 and run=0; score holds.
- **Score limit.** In PLAY, 3 score_event pulses. Required: score=3 and OVER after the 3rd pulse. Further pulses leave score=3.
- **Pause.**
  - Apply 2 ticks, a keycode2=8'h13 edge, then 10 ticks while paused: time_left=3, fcnt held, paused=1.
  - A second PAUSE edge returns to PLAY; time_left reaches 2 after exactly 2 more ticks.
- **Held key and dual slot.** keycode=keycode2=8'h2C held for 20 cycles in IDLE. Required: a single transition to COUNTDOWN, no retrigger.
- **Abort and reset.**
  - game_active dropped mid-PLAY: IDLE next cycle with score=0 and time_left=3.
  - Reset_n pulsed low between clock edges mid-COUNTDOWN: outputs take reset values immediately.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Round sequencer for GAME1/GAME2: start countdown, timed play with pause/resume,
// and a game-over hold. Key commands arrive on the shared USB keycode slots.
`timescale 1ns/1ps
module game_round_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int ROUND_SEC      = 60,
  parameter int SCORE_LIMIT    = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       game_active,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode2,
  input  logic       score_event,
  output logic       run,
  output logic       paused,
  output logic       game_over,
  output logic       round_start,
  output logic [3:0] countdown,
  output logic [7:0] time_left,
  output logic [7:0] score
);

  localparam logic [7:0] KEY_START = 8'h2C;
  localparam logic [7:0] KEY_PAUSE = 8'h13;
  localparam logic [7:0] FCNT_MAX  = 8'(FRAMES_PER_SEC - 1);
  localparam logic [3:0] CD_INIT   = 4'(COUNTDOWN_SEC);
  localparam logic [7:0] TL_INIT   = 8'(ROUND_SEC);
  localparam logic [7:0] SC_LIMIT  = 8'(SCORE_LIMIT);
  localparam logic [7:0] SC_LAST   = 8'(SCORE_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, PAUSE, OVER} state_t;

  state_t     state, state_next;
  logic [7:0] fcnt, fcnt_next, fcnt_adv;
  logic [3:0] cd_next;
  logic [7:0] tl_next, score_next;
  logic       rs_next;
  logic       start_prev, pause_prev;
  logic       start_pressed, pause_pressed, start_edge, pause_edge;
  logic       sec;

  // Either slot holding the key counts as one press, so both slots at once give one edge.
  assign start_pressed = (keycode == KEY_START) || (keycode2 == KEY_START);
  assign pause_pressed = (keycode == KEY_PAUSE) || (keycode2 == KEY_PAUSE);
  assign start_edge    = start_pressed && !start_prev;
  assign pause_edge    = pause_pressed && !pause_prev;

  assign sec      = frame_tick && (fcnt == FCNT_MAX);
  assign fcnt_adv = sec ? 8'd0 : fcnt + 8'd1;

  assign run       = (state == PLAY);
  assign paused    = (state == PAUSE);
  assign game_over = (state == OVER);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      fcnt        <= 8'd0;
      countdown   <= CD_INIT;
      time_left   <= TL_INIT;
      score       <= 8'd0;
      round_start <= 1'b0;
      start_prev  <= 1'b0;
      pause_prev  <= 1'b0;
    end else begin
      state       <= state_next;
      fcnt        <= fcnt_next;
      countdown   <= cd_next;
      time_left   <= tl_next;
      score       <= score_next;
      round_start <= rs_next;
      start_prev  <= start_pressed;
      pause_prev  <= pause_pressed;
    end
  end

  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    cd_next    = countdown;
    tl_next    = time_left;
    score_next = score;
    rs_next    = 1'b0;

    if (!game_active) begin
      state_next = IDLE;
      fcnt_next  = 8'd0;
      cd_next    = CD_INIT;
      tl_next    = TL_INIT;
      score_next = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          fcnt_next  = 8'd0;
          cd_next    = CD_INIT;
          tl_next    = TL_INIT;
          score_next = 8'd0;
          if (start_edge) state_next = COUNTDOWN;
        end
        COUNTDOWN: begin
          if (frame_tick) fcnt_next = fcnt_adv;
          if (sec) begin
            cd_next = countdown - 4'd1;
            if (countdown == 4'd1) begin
              state_next = PLAY;
              rs_next    = 1'b1;
            end
          end
        end
        PLAY: begin
          if (frame_tick) fcnt_next = fcnt_adv;
          if (sec) tl_next = time_left - 8'd1;
          if (score_event && (score < SC_LIMIT)) score_next = score + 8'd1;
          // Timeout and score limit both end the round and win over a pause request.
          if ((sec && (time_left == 8'd1)) || (score_event && (score == SC_LAST)))
            state_next = OVER;
          else if (pause_edge)
            state_next = PAUSE;
        end
        PAUSE: begin
          if (pause_edge) state_next = PLAY;
        end
        OVER: begin
          fcnt_next = 8'd0;
          if (start_edge) begin
            state_next = COUNTDOWN;
            cd_next    = CD_INIT;
            tl_next    = TL_INIT;
            score_next = 8'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: stimulus queues expected outputs, a monitor
// pops one entry per falling clock edge and compares it with the DUT.
`timescale 1ns/1ps
module tb_game_round_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       game_active;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [7:0] keycode2;
  logic       score_event;
  logic       run, paused, game_over, round_start;
  logic [3:0] countdown;
  logic [7:0] time_left, score;

  typedef struct {
    string       name;
    logic [23:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [23:0] act;
  int          checks = 0;
  int          fails  = 0;

  game_round_ctrl #(
    .FRAMES_PER_SEC(4),
    .COUNTDOWN_SEC (2),
    .ROUND_SEC     (3),
    .SCORE_LIMIT   (3)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .game_active(game_active),
    .frame_tick (frame_tick),
    .keycode    (keycode),
    .keycode2   (keycode2),
    .score_event(score_event),
    .run        (run),
    .paused     (paused),
    .game_over  (game_over),
    .round_start(round_start),
    .countdown  (countdown),
    .time_left  (time_left),
    .score      (score)
  );

  always #5 Clk = ~Clk;

  // Monitor: compares the oldest queued expectation on every falling edge.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {run, paused, game_over, round_start, countdown, time_left, score};
      checks++;
      if (act !== cur.v) begin
        fails++;
        $display("[TB] FAIL %s: got run/pau/ovr/rs=%b cd=%0d tl=%0d sc=%0d, expected run/pau/ovr/rs=%b cd=%0d tl=%0d sc=%0d",
                 cur.name, act[23:20], act[19:16], act[15:8], act[7:0],
                 cur.v[23:20], cur.v[19:16], cur.v[15:8], cur.v[7:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic ft, input logic se,
                               input logic [7:0] k1, input logic [7:0] k2);
    frame_tick  = ft;
    score_event = se;
    keycode     = k1;
    keycode2    = k2;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic r, input logic p,
                             input logic g, input logic rs, input logic [3:0] cd,
                             input logic [7:0] tl, input logic [7:0] sc);
    exp_t e;
    e.name = name;
    e.v    = {r, p, g, rs, cd, tl, sc};
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    Reset_n     = 1'b0;
    game_active = 1'b0;
    frame_tick  = 1'b0;
    score_event = 1'b0;
    keycode     = 8'h00;
    keycode2    = 8'h00;
    @(posedge Clk);
    #1;
    checkOutput("reset_state", 0, 0, 0, 0, 4'd2, 8'd3, 8'd0);
    @(posedge Clk);
    #1;
    Reset_n     = 1'b1;
    game_active = 1'b1;

    $display("[TB] start and countdown");
    applyStimulus(1'b0, 1'b0, 8'h2C, 8'h00);
    ticks(3);
    checkOutput("cd_tick3", 0, 0, 0, 0, 4'd2, 8'd3, 8'd0);
    ticks(1);
    checkOutput("cd_tick4", 0, 0, 0, 0, 4'd1, 8'd3, 8'd0);
    ticks(3);
    checkOutput("cd_tick7", 0, 0, 0, 0, 4'd1, 8'd3, 8'd0);
    ticks(1);
    checkOutput("play_entry", 1, 0, 0, 1, 4'd0, 8'd3, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("round_start_once", 1, 0, 0, 0, 4'd0, 8'd3, 8'd0);

    $display("[TB] timeout");
    ticks(4);
    checkOutput("tl_after_4", 1, 0, 0, 0, 4'd0, 8'd2, 8'd0);
    ticks(7);
    checkOutput("tl_after_11", 1, 0, 0, 0, 4'd0, 8'd1, 8'd0);
    ticks(1);
    checkOutput("timeout_over", 0, 0, 1, 0, 4'd0, 8'd0, 8'd0);
    applyStimulus(1'b1, 1'b1, 8'h13, 8'h00);
    checkOutput("over_hold", 0, 0, 1, 0, 4'd0, 8'd0, 8'd0);

    $display("[TB] score limit");
    applyStimulus(1'b0, 1'b0, 8'h2C, 8'h00);
    checkOutput("restart_reload", 0, 0, 0, 0, 4'd2, 8'd3, 8'd0);
    ticks(8);
    checkOutput("play_entry2", 1, 0, 0, 1, 4'd0, 8'd3, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    checkOutput("score_1", 1, 0, 0, 0, 4'd0, 8'd3, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    checkOutput("score_2", 1, 0, 0, 0, 4'd0, 8'd3, 8'd2);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    checkOutput("score_limit_over", 0, 0, 1, 0, 4'd0, 8'd3, 8'd3);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    checkOutput("score_saturate", 0, 0, 1, 0, 4'd0, 8'd3, 8'd3);

    $display("[TB] pause");
    applyStimulus(1'b0, 1'b0, 8'h2C, 8'h00);
    ticks(8);
    ticks(2);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h13);
    checkOutput("pause_enter", 0, 1, 0, 0, 4'd0, 8'd3, 8'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'h00, 8'h00);
    checkOutput("pause_hold", 0, 1, 0, 0, 4'd0, 8'd3, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h13);
    checkOutput("pause_resume", 1, 0, 0, 0, 4'd0, 8'd3, 8'd0);
    ticks(1);
    checkOutput("resume_tick1", 1, 0, 0, 0, 4'd0, 8'd3, 8'd0);
    ticks(1);
    checkOutput("resume_tick2", 1, 0, 0, 0, 4'd0, 8'd2, 8'd0);

    $display("[TB] abort");
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    checkOutput("pre_abort_score", 1, 0, 0, 0, 4'd0, 8'd2, 8'd1);
    game_active = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("abort_idle", 0, 0, 0, 0, 4'd2, 8'd3, 8'd0);
    game_active = 1'b1;

    $display("[TB] held key and dual slot");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 8'h2C, 8'h2C);
    ticks(4);
    checkOutput("held_single_start", 0, 0, 0, 0, 4'd1, 8'd3, 8'd0);
    game_active = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h2C, 8'h2C);
    game_active = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h2C, 8'h2C);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h2C, 8'h2C);
    checkOutput("held_no_retrigger", 0, 0, 0, 0, 4'd2, 8'd3, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h2C);
    ticks(4);
    checkOutput("slot2_start", 0, 0, 0, 0, 4'd1, 8'd3, 8'd0);

    $display("[TB] async reset");
    ticks(1);
    #2;
    Reset_n = 1'b0;
    checkOutput("reset_async", 0, 0, 0, 0, 4'd2, 8'd3, 8'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    ticks(4);
    checkOutput("post_reset_idle", 0, 0, 0, 0, 4'd2, 8'd3, 8'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clk);
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
